// File: rtl/trng_vn_collector.sv
// Entropy collector for the ring-oscillator TRNG: decimation, von Neumann
// debiasing, stuck-source health check and word packing onto valid/ready.
module trng_vn_collector #(
    parameter int WIDTH       = 8,
    parameter int SAMPLE_DIV  = 4,
    parameter int WARMUP      = 16,
    parameter int STUCK_LIMIT = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             raw_bit,
    output logic             ro_stop,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             stuck,
    input  logic             clear_fault
);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(STUCK_LIMIT + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(STUCK_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAULT
    } state_t;

    state_t           state, state_n;
    logic [1:0]       sync;
    logic [WW-1:0]    warm_cnt;
    logic [DW-1:0]    div;
    logic [BW-1:0]    bit_cnt;
    logic [RW-1:0]    rep, rep_n;
    logic             pend, pend_bit, last_smp, smp;
    logic [WIDTH-1:0] shreg, word;
    logic             strobe, emit, done, fault, load, out_free, run;

    assign smp      = sync[1];
    assign out_free = !valid || ready;
    assign run      = (state == S_COLLECT || state == S_HOLD) &&
                      (state_n == S_COLLECT || state_n == S_HOLD);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        strobe  = 1'b0;
        emit    = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        load    = 1'b0;
        rep_n   = rep;
        word    = shreg;
        unique case (state)
            S_IDLE: if (start) state_n = S_WARMUP;
            S_WARMUP: begin
                if (!start)                    state_n = S_IDLE;
                else if (warm_cnt == WARM_LAST) state_n = S_COLLECT;
            end
            S_COLLECT: begin
                strobe = (div == DIV_LAST);
                word   = {shreg[WIDTH-2:0], pend_bit};
                if (strobe) begin
                    rep_n = (rep != '0 && smp == last_smp) ? rep + 1'b1 : RW'(1);
                    emit  = pend && (pend_bit != smp);
                    done  = emit && (bit_cnt == BIT_LAST);
                    fault = (rep_n == REP_MAX);
                end
                // A health fault outranks both a stop request and a finished word
                if (fault)         state_n = S_FAULT;
                else if (!start)   state_n = S_IDLE;
                else if (done) begin
                    if (out_free) load    = 1'b1;
                    else          state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!start) state_n = S_IDLE;
                else if (out_free) begin
                    load    = 1'b1;
                    state_n = S_COLLECT;
                end
            end
            S_FAULT: if (clear_fault) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            ro_stop  <= 1'b1;
            stuck    <= 1'b0;
            valid    <= 1'b0;
            data     <= '0;
            warm_cnt <= '0;
            div      <= '0;
            bit_cnt  <= '0;
            rep      <= '0;
            pend     <= 1'b0;
            pend_bit <= 1'b0;
            last_smp <= 1'b0;
            shreg    <= '0;
        end else begin
            sync    <= {sync[0], raw_bit};
            ro_stop <= (state_n == S_IDLE) || (state_n == S_FAULT);
            stuck   <= (state_n == S_FAULT);
            if (load) begin
                valid <= 1'b1;
                data  <= word;
            end else if (ready) begin
                valid <= 1'b0;
            end
            warm_cnt <= (state == S_WARMUP) ? warm_cnt + 1'b1 : '0;
            if (!run) begin
                div      <= '0;
                bit_cnt  <= '0;
                rep      <= '0;
                pend     <= 1'b0;
                pend_bit <= 1'b0;
                last_smp <= 1'b0;
                shreg    <= '0;
            end else if (state == S_COLLECT) begin
                div <= strobe ? '0 : div + 1'b1;
                if (strobe) begin
                    pend     <= !pend;
                    rep      <= rep_n;
                    last_smp <= smp;
                    if (!pend) pend_bit <= smp;
                end
                if (emit) begin
                    shreg   <= word;
                    bit_cnt <= load ? '0 : bit_cnt + 1'b1;
                end
            end else if (load) begin
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_trng_vn_collector.sv
// Scoreboard bench for trng_vn_collector: default instance plus a
// SAMPLE_DIV=1 instance for the every-clock strobe case.
module tb_trng_vn_collector;
    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start, raw_bit, ready, clear_fault;
    logic       ro_stop, valid, stuck;
    logic [7:0] data;
    logic       start1, raw1, ready1, clear1;
    logic       ro_stop1, valid1, stuck1;
    logic [7:0] data1;
    int         checks = 0;
    int         failures = 0;
    logic       src[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    always #5 clock = ~clock;

    trng_vn_collector u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .raw_bit(raw_bit),
        .ro_stop(ro_stop), .data(data), .valid(valid), .ready(ready),
        .stuck(stuck), .clear_fault(clear_fault)
    );

    trng_vn_collector #(.SAMPLE_DIV(1)) u_div1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .raw_bit(raw1),
        .ro_stop(ro_stop1), .data(data1), .valid(valid1), .ready(ready1),
        .stuck(stuck1), .clear_fault(clear1)
    );

    // Sample k of the default instance is taken from raw driven at tick 18+4k.
    task automatic tick(input int j);
        @(negedge clock);
        if (j >= 15 && (j - 15) / 4 < src.size()) raw_bit = src[(j - 15) / 4];
        else raw_bit = ((j / 4) % 2) == 1;
    endtask

    task automatic push_bits(input logic [7:0] w, input int n, input bit expect_it);
        for (int i = 7; i >= 8 - n; i--) begin
            src.push_back(w[i]);
            src.push_back(!w[i]);
        end
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic pop_check(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected word got=%h", name, data);
        end else begin
            exp_w = exp_q.pop_front();
            if (data !== exp_w) begin
                failures++;
                $display("FAIL %s data got=%h exp=%h", name, data, exp_w);
            end
        end
    endtask

    task automatic test_reset();
        start = 0; raw_bit = 0; ready = 0; clear_fault = 0;
        start1 = 0; raw1 = 0; ready1 = 0; clear1 = 0;
        @(negedge clock);
        reset_n = 0;
        repeat (2) @(negedge clock);
        checks += 5;
        if (ro_stop !== 1'b1) begin failures++; $display("FAIL rst_ro_stop got=%b exp=1", ro_stop); end
        if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
        if (data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data); end
        if (stuck !== 1'b0) begin failures++; $display("FAIL rst_stuck got=%b exp=0", stuck); end
        if (ro_stop1 !== 1'b1) begin failures++; $display("FAIL rst_ro_stop1 got=%b exp=1", ro_stop1); end
        reset_n = 1;
    endtask

    task automatic test_stuck_warmup();
        src.delete();
        repeat (40) src.push_back(1'b1);
        ready = 1;
        for (int j = 0; j <= 149; j++) begin
            tick(j);
            if (j == 0) start = 1;
            if (j == 1) begin
                checks++;
                if (ro_stop !== 1'b0) begin failures++; $display("FAIL warm_ro_stop got=%b exp=0", ro_stop); end
            end
            if (j == 144) begin
                checks++;
                if (stuck !== 1'b0) begin failures++; $display("FAIL stuck_early got=%b exp=0", stuck); end
            end
            if (j == 145) begin
                checks += 3;
                if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_rise got=%b exp=1", stuck); end
                if (ro_stop !== 1'b1) begin failures++; $display("FAIL stuck_ro_stop got=%b exp=1", ro_stop); end
                if (valid !== 1'b0) begin failures++; $display("FAIL stuck_no_word got=%b exp=0", valid); end
                start = 0;
            end
            if (j == 146) begin
                checks++;
                if (stuck !== 1'b1) begin failures++; $display("FAIL fault_start0 got=%b exp=1", stuck); end
                start = 1;
                clear_fault = 1;
            end
            if (j == 147) begin
                checks += 2;
                if (stuck !== 1'b0) begin failures++; $display("FAIL clear_stuck got=%b exp=0", stuck); end
                if (ro_stop !== 1'b1) begin failures++; $display("FAIL clear_idle got=%b exp=1", ro_stop); end
                clear_fault = 0;
            end
            if (j == 148) begin
                checks++;
                if (ro_stop !== 1'b0) begin failures++; $display("FAIL rewarm got=%b exp=0", ro_stop); end
                start = 0;
            end
        end
    endtask

    task automatic test_vn_div1();
        logic [19:0] pat;
        int          nvalid;
        pat = 20'h9C999;
        nvalid = 0;
        exp_q.push_back(8'hAA);
        for (int j = 0; j <= 50; j++) begin
            tick(j);
            if (j == 0) begin start1 = 1; ready1 = 1; end
            raw1 = (j >= 15 && j < 35) ? pat[34 - j] : 1'b1;
            if (valid1) begin
                nvalid++;
                checks++;
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if (data1 !== exp_w) begin failures++; $display("FAIL div1_data got=%h exp=%h", data1, exp_w); end
            end
            if (j == 37) begin
                checks++;
                if (valid1 !== 1'b1) begin failures++; $display("FAIL div1_timing got=%b exp=1", valid1); end
            end
        end
        start1 = 0;
        checks++;
        if (nvalid !== 1) begin failures++; $display("FAIL div1_valid_len got=%0d exp=1", nvalid); end
    endtask

    task automatic test_back_to_back();
        src.delete();
        push_bits(8'hC5, 8, 1);
        push_bits(8'h3A, 8, 1);
        ready = 0;
        for (int j = 0; j <= 180; j++) begin
            tick(j);
            if (j == 0) start = 1;
            if (j == 81 || j == 165) begin
                checks += 2;
                if (valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_valid got=%b exp=1", valid); end
                if (data !== exp_q[0]) begin failures++; $display("FAIL b2b_stable got=%h exp=%h", data, exp_q[0]); end
            end
            if (j == 170) ready = 1;
            if (j == 172) begin
                checks++;
                if (valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid); end
            end
            if (j == 175) start = 0;
            if (valid && ready) pop_check("b2b");
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_start_drop();
        src.delete();
        push_bits(8'h96, 8, 1);
        push_bits(8'hB0, 5, 0);
        ready = 0;
        for (int j = 0; j <= 125; j++) begin
            tick(j);
            if (j == 0) start = 1;
            if (j == 121) begin
                checks++;
                if (valid !== 1'b1) begin failures++; $display("FAIL drop_prior got=%b exp=1", valid); end
                start = 0;
            end
            if (j == 122) begin
                checks++;
                if (ro_stop !== 1'b1) begin failures++; $display("FAIL drop_ro_stop got=%b exp=1", ro_stop); end
            end
            if (j == 123) ready = 1;
            if (j == 124) begin
                checks++;
                if (valid !== 1'b0) begin failures++; $display("FAIL drop_consumed got=%b exp=0", valid); end
            end
            if (valid && ready) pop_check("drop_prior_word");
        end
        src.delete();
        push_bits(8'h4D, 8, 1);
        for (int j = 0; j <= 90; j++) begin
            tick(j);
            if (j == 0) start = 1;
            if (j == 81) begin
                checks++;
                if (valid !== 1'b1) begin failures++; $display("FAIL restart_timing got=%b exp=1", valid); end
            end
            if (valid && ready) pop_check("restart_word");
        end
        start = 0;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL restart_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        src.delete();
        push_bits(8'hE1, 8, 1);
        push_bits(8'h7E, 8, 1);
        ready = 0;
        for (int j = 0; j <= 150; j++) begin
            tick(j);
            if (j == 0) start = 1;
        end
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL hold_ctx got=%b exp=1", valid); end
        #2 reset_n = 0;
        #1;
        checks += 4;
        if (valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", valid); end
        if (data !== 8'h00) begin failures++; $display("FAIL arst_data got=%h exp=00", data); end
        if (ro_stop !== 1'b1) begin failures++; $display("FAIL arst_ro_stop got=%b exp=1", ro_stop); end
        if (stuck !== 1'b0) begin failures++; $display("FAIL arst_stuck got=%b exp=0", stuck); end
        exp_q.delete();
        start = 0;
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_stuck_warmup();
        test_vn_div1();
        test_back_to_back();
        test_start_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
